// File: rtl/dmem_mp.sv
// rtl/dmem_mp.sv - multi-read-port data memory with self-clearing init and byte/half/word writes
module dmem_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1024,
    parameter int NUM_RD     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic [NUM_RD-1:0]      rd_req,
    input  logic [NUM_RD*32-1:0]   rd_addr,
    output logic [NUM_RD-1:0]      rd_valid,
    output logic [NUM_RD*32-1:0]   rd_data,
    output logic [NUM_RD-1:0]      rd_err,
    input  logic                   wr_req,
    input  logic [31:0]            wr_addr,
    input  logic [1:0]             wr_size,
    input  logic [31:0]            wr_data,
    output logic                   wr_done,
    output logic                   wr_err
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_next;
    logic                    clr_we;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [3:0]              wr_be;
    logic [DATA_WIDTH-1:0]   wr_lanes;
    logic [DATA_WIDTH-1:0]   wr_merged;
    logic                    wr_acc, wr_bad, wr_ok;

    logic [ADDR_WIDTH-1:0]   rd_idx  [NUM_RD];
    logic [DATA_WIDTH-1:0]   rd_word [NUM_RD];
    logic [NUM_RD-1:0]       rd_oor;
    logic [NUM_RD-1:0]       unused_rd_lsbs;

    assign ready = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        clr_we       = 1'b0;
        case (state)
            INIT: begin
                clr_we = 1'b1;
                if (clr_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_next   = RUN;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Write decode: lane enables, replicated store data and the rejection conditions.
    always_comb begin
        wr_idx   = wr_addr[ADDR_WIDTH+1:2];
        wr_be    = 4'b0000;
        wr_lanes = wr_data;
        wr_bad   = |wr_addr[31:ADDR_WIDTH+2];
        case (wr_size)
            2'b00: begin
                wr_be    = 4'b0001 << wr_addr[1:0];
                wr_lanes = {4{wr_data[7:0]}};
            end
            2'b01: begin
                wr_be    = wr_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wr_data[15:0]}};
                wr_bad   = wr_bad | wr_addr[0];
            end
            2'b10: begin
                wr_be    = 4'b1111;
                wr_bad   = wr_bad | (|wr_addr[1:0]);
            end
            default: wr_bad = 1'b1;
        endcase
        wr_acc = ready & wr_req;
        wr_ok  = wr_acc & ~wr_bad;
        for (int l = 0; l < 4; l++) begin
            wr_merged[l*DATA_SIZE +: DATA_SIZE] = wr_be[l] ? wr_lanes[l*DATA_SIZE +: DATA_SIZE]
                                                           : mem[wr_idx][l*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Reads see the merged post-write word when a good write hits the same index.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_idx[i]         = rd_addr[32*i+2 +: ADDR_WIDTH];
            rd_oor[i]         = |rd_addr[32*i+ADDR_WIDTH+2 +: 30-ADDR_WIDTH];
            unused_rd_lsbs[i] = ^rd_addr[32*i +: 2];
            if (rd_oor[i])
                rd_word[i] = '0;
            else if (wr_ok && (rd_idx[i] == wr_idx))
                rd_word[i] = wr_merged;
            else
                rd_word[i] = mem[rd_idx[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we)
                mem[clr_cnt] <= '0;
            else if (wr_ok)
                mem[wr_idx] <= wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= '0;
            rd_data  <= '0;
            rd_err   <= '0;
            wr_done  <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            wr_done <= wr_ok;
            wr_err  <= wr_acc & wr_bad;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_valid[i] <= ready & rd_req[i];
                if (ready && rd_req[i]) begin
                    rd_data[32*i +: 32] <= rd_word[i];
                    rd_err[i]           <= rd_oor[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_mp.sv
// tb/tb_dmem_mp.sv - scoreboard bench for dmem_mp against a byte-addressed reference model
module tb_dmem_mp;
    localparam int NR    = 3;
    localparam int DEPTH = 1024;
    localparam int BYTES = DEPTH * 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ready;
    logic [NR-1:0]     rd_req = '0;
    logic [NR*32-1:0]  rd_addr = '0;
    logic [NR-1:0]     rd_valid;
    logic [NR*32-1:0]  rd_data;
    logic [NR-1:0]     rd_err;
    logic              wr_req = 1'b0;
    logic [31:0]       wr_addr = '0;
    logic [1:0]        wr_size = '0;
    logic [31:0]       wr_data = '0;
    logic              wr_done, wr_err;

    always #5 clk = ~clk;

    dmem_mp #(.DATA_WIDTH(32), .DATA_SIZE(8), .ADDR_WIDTH(10), .RAM_DEPTH(DEPTH), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
        .wr_done(wr_done), .wr_err(wr_err)
    );

    typedef struct { int cyc; logic [31:0] d; logic e; } rexp_t;
    typedef struct { int cyc; logic e; } wexp_t;

    rexp_t       rq [NR][$];
    wexp_t       wq [$];
    logic [7:0]  mbytes [0:BYTES-1];
    logic [31:0] last_d [NR];
    logic        last_e [NR];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'd3;
        return {mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < BYTES; k++) mbytes[k] = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 85) return 32'($urandom_range(0, 127));
        else if (r < 92) return 32'h0000_1000 + 32'($urandom_range(0, 15));
        else return $urandom;
    endfunction

    // Apply one cycle of stimulus; when live, the model is updated and responses are expected.
    task automatic drive(input bit live, input bit wr, input logic [31:0] wa, input logic [1:0] ws,
                         input logic [31:0] wd, input logic [NR-1:0] rr, input logic [NR*32-1:0] ra);
        logic        bad;
        logic [31:0] a;
        wr_req = wr; wr_addr = wa; wr_size = ws; wr_data = wd;
        rd_req = rr; rd_addr = ra;
        if (live) begin
            if (wr) begin
                bad = (ws == 2'b11) || (ws == 2'b01 && wa[0]) || (ws == 2'b10 && wa[1:0] != 2'b00)
                      || (wa >= 32'(BYTES));
                if (!bad)
                    for (int k = 0; k < (1 << ws); k++) mbytes[wa + 32'(k)] = wd[8*k +: 8];
                wq.push_back(wexp_t'{cyc + 1, bad});
            end
            for (int i = 0; i < NR; i++) begin
                if (rr[i]) begin
                    a = ra[32*i +: 32];
                    if (a >= 32'(BYTES)) rq[i].push_back(rexp_t'{cyc + 1, 32'h0, 1'b1});
                    else                 rq[i].push_back(rexp_t'{cyc + 1, model_word(a), 1'b0});
                end
            end
        end
        tick();
        wr_req = 1'b0;
        rd_req = '0;
    endtask

    task automatic drive_random(input bit live);
        logic [NR*32-1:0] ra;
        logic [31:0]      wa;
        wa = rand_addr();
        for (int i = 0; i < NR; i++)
            ra[32*i +: 32] = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
        drive(live, 1'($urandom), wa, 2'($urandom), $urandom, NR'($urandom), ra);
    endtask

    task automatic read1(input int port, input logic [31:0] a);
        logic [NR*32-1:0] ra;
        ra = '0;
        ra[32*port +: 32] = a;
        drive(1'b1, 1'b0, 32'h0, 2'b00, 32'h0, NR'(1 << port), ra);
    endtask

    task automatic write1(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        drive(1'b1, 1'b1, a, s, d, '0, '0);
    endtask

    // Reset with random (ignored) requests, then run through the clear phase counting cycles.
    task automatic reset_and_init(input int hold);
        bit low_ok;
        rst = 1'b1;
        drive_random(1'b0);
        mon_en = 1'b1;
        for (int i = 0; i < NR; i++) begin last_d[i] = '0; last_e[i] = 1'b0; end
        model_clear();
        for (int h = 1; h < hold; h++) drive_random(1'b0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data[31:0], 32'd0);
        chk("rst_wr_strobes", {30'd0, wr_done, wr_err}, 32'd0);
        rst = 1'b0;
        low_ok = 1'b1;
        for (int j = 1; j <= DEPTH; j++) begin
            drive_random(1'b0);
            if (j < DEPTH && ready !== 1'b0) low_ok = 1'b0;
        end
        chk("init_ready_low", 32'(low_ok), 32'd1);
        chk("ready_rise", 32'(ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NR; i++) begin
                if (rd_valid[i]) begin
                    if (rq[i].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_unexpected port %0d: got rd_valid=1 expected 0 (cycle %0d)", i, cyc);
                    end else begin
                        rexp_t e;
                        e = rq[i].pop_front();
                        chk($sformatf("rd_latency p%0d", i), 32'(cyc), 32'(e.cyc));
                        chk($sformatf("rd_data p%0d", i), rd_data[32*i +: 32], e.d);
                        chk($sformatf("rd_err p%0d", i), 32'(rd_err[i]), 32'(e.e));
                        last_d[i] = e.d;
                        last_e[i] = e.e;
                    end
                end else begin
                    chk($sformatf("rd_hold p%0d", i), {rd_data[32*i +: 31], rd_err[i]},
                        {last_d[i][30:0], last_e[i]});
                    if (rq[i].size() > 0 && rq[i][0].cyc <= cyc) begin
                        void'(rq[i].pop_front());
                        checks++; errors++;
                        $display("FAIL rd_missing port %0d: got rd_valid=0 expected 1 (cycle %0d)", i, cyc);
                    end
                end
            end
            if (wr_done || wr_err) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got done=%0b err=%0b expected none (cycle %0d)", wr_done, wr_err, cyc);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    chk("wr_latency", 32'(cyc), 32'(w.cyc));
                    chk("wr_done_err", {30'd0, wr_done, wr_err}, {30'd0, ~w.e, w.e});
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                void'(wq.pop_front());
                checks++; errors++;
                $display("FAIL wr_missing: got no strobe expected one (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        reset_and_init(3);

        // Words targeted by the ignored init-phase writes must still be zero.
        for (int a = 0; a < 128; a += 12) begin
            logic [NR*32-1:0] ra;
            for (int i = 0; i < NR; i++) ra[32*i +: 32] = 32'(a + 4*i);
            drive(1'b1, 1'b0, '0, '0, '0, '1, ra);
        end
        read1(0, 32'h3FC);

        write1(32'h10, 2'b10, 32'hDEADBEEF);
        write1(32'h12, 2'b00, 32'h00000055);
        read1(0, 32'h10);
        write1(32'h21, 2'b01, 32'h0000ABCD);
        read1(1, 32'h20);
        write1(32'h1000, 2'b10, 32'h11111111);
        read1(2, 32'h1000);
        write1(32'h22, 2'b01, 32'h0000CAFE);
        write1(32'h27, 2'b00, 32'h000000A5);
        write1(32'h2E, 2'b11, 32'hFFFFFFFF);
        drive(1'b1, 1'b1, 32'h40, 2'b10, 32'h12345678, 3'b111, {32'h40, 32'h41, 32'h43});

        for (int n = 0; n < 400; n++) drive_random(1'b1);

        write1(32'h40, 2'b10, 32'hA5A5A5A5);
        reset_and_init(2);
        read1(0, 32'h10);
        drive(1'b1, 1'b0, '0, '0, '0, 3'b111, {32'h40, 32'h20, 32'h3FC});
        for (int n = 0; n < 60; n++) drive_random(1'b1);

        for (int n = 0; n < 3; n++) tick();
        chk("rd_queue_drained", 32'(rq[0].size() + rq[1].size() + rq[2].size()), 32'd0);
        chk("wr_queue_drained", 32'(wq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
